// File: rtl/edge_pkg.sv
// Shared types for the edge event arbiter: per-line detector states and
// the arbiter handshake states.
package edge_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'b00,
        EDGE = 2'b01,
        HIGH = 2'b10
    } det_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/edge_detect.sv
// Moore rising-edge detector for one synchronous level input.
// edge_pulse is high for exactly one cycle per 0->1 transition, one cycle
// after the clock edge that sampled the new high level.
//
// state | meaning
// ------+--------------------------------------------------------------
// LOW   | input last sampled low, armed for the next rising edge
// EDGE  | first cycle after a 0->1 transition, pulse is asserted
// HIGH  | input has stayed high, or reset (no event until it drops)
module edge_detect
    import edge_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic edge_pulse
);

    det_state_t state;

    // State walk and registered pulse; reset parks in HIGH so a line held
    // high through reset does not look like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HIGH;
            edge_pulse <= 1'b0;
        end else if (!in) begin
            state      <= LOW;
            edge_pulse <= 1'b0;
        end else begin
            case (state)
                LOW: begin
                    state      <= EDGE;
                    edge_pulse <= 1'b1;
                end
                EDGE: begin
                    state      <= HIGH;
                    edge_pulse <= 1'b0;
                end
                HIGH: begin
                    state      <= HIGH;
                    edge_pulse <= 1'b0;
                end
                default: begin
                    state      <= HIGH;
                    edge_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects rising edges on N level inputs into per-line pending flags and
// offers them one at a time to a valid/ready consumer in round-robin order.
// A second edge on a line that is still pending is lost and flagged in the
// sticky overrun vector.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no offer outstanding; picks the next pending line if any
// OFFER | evt_valid high, evt_id frozen until the consumer accepts
module edge_event_arbiter
    import edge_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overrun,
    input  logic           ovf_clr
);

    localparam int SW = IDW + 1;

    arb_state_t     state;
    logic [IDW-1:0] last_grant;
    logic [N-1:0]   edge_pulse;
    logic [N-1:0]   grant_clr;
    logic [SW-1:0]  rr_start;
    logic [IDW-1:0] rr_hi;
    logic [IDW-1:0] rr_lo;
    logic           rr_hit_hi;
    logic           rr_winner_unused;
    logic [IDW-1:0] rr_winner;

    for (genvar g = 0; g < N; g++) begin : g_det
        edge_detect u_det (
            .clk        (clk),
            .rst_n      (rst_n),
            .in         (in[g]),
            .edge_pulse (edge_pulse[g])
        );
    end

    // One-hot clear for the line whose offer is accepted this cycle.
    always_comb begin
        grant_clr = '0;
        for (int i = 0; i < N; i++) begin
            grant_clr[i] = evt_valid & evt_ready & (evt_id == IDW'(i));
        end
    end

    // Round-robin pick: lowest pending index at or above last_grant+1,
    // otherwise wrap to the lowest pending index overall.
    always_comb begin
        if (last_grant == IDW'(N - 1)) begin
            rr_start = '0;
        end else begin
            rr_start = {1'b0, last_grant} + SW'(1);
        end
        rr_hi            = '0;
        rr_lo            = '0;
        rr_hit_hi        = 1'b0;
        rr_winner_unused = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                rr_lo            = IDW'(i);
                rr_winner_unused = 1'b1;
                if (SW'(i) >= rr_start) begin
                    rr_hi     = IDW'(i);
                    rr_hit_hi = 1'b1;
                end
            end
        end
        rr_winner = rr_hit_hi ? rr_hi : rr_lo;
    end

    // Pending and overrun flags; an accept and a new edge on the same line
    // in one cycle keep the line pending without counting as a loss, and a
    // new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~grant_clr) | edge_pulse;
            overrun <= (overrun & ~{N{ovf_clr}}) | (edge_pulse & pending & ~grant_clr);
        end
    end

    // Offer FSM with registered evt_valid/evt_id; a new winner is only
    // latched from IDLE, so sustained throughput is one event per two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= IDW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (rr_winner_unused) begin
                        state     <= OFFER;
                        evt_valid <= 1'b1;
                        evt_id    <= rr_winner;
                    end else begin
                        evt_valid <= 1'b0;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        state      <= IDLE;
                        evt_valid  <= 1'b0;
                        last_grant <= evt_id;
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N, default 4: number of monitored input lines, 2..16.
REQ-002 Parameter IDW, default $clog2(N): event-ID width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  N  level inputs, already synchronous to clk.
REQ-006 evt_valid  output  1  event offered to consumer.
REQ-007 evt_id  output  IDW  index of the line whose rising edge is offered.
REQ-008 evt_ready  input  1  consumer accepts the event when high with evt_valid.
REQ-009 pending  output  N  per-line event-waiting flags.
REQ-010 overrun  output  N  sticky per-line lost-event flags.
REQ-011 ovf_clr  input  1  single-cycle pulse; clears all overrun bits.

Function
REQ-012 Each line SHALL have a Moore rising-edge detector with states LOW, EDGE and HIGH; in=1 moves LOW->EDGE, EDGE->HIGH and HIGH->HIGH; in=0 moves any state to LOW.
REQ-013 Detector output edge[i] SHALL be 1 only in state EDGE, giving one pulse per 0->1 transition, registered one cycle after the sampling clock edge.
REQ-014 pending[i] next value SHALL be (pending[i] & ~grant_clr[i]) | edge[i].
REQ-015 grant_clr[i] SHALL be 1 only in the cycle where evt_valid & evt_ready & evt_id==i.
REQ-016 An edge[i] pulse while pending[i]=1 and grant_clr[i]=0 SHALL set overrun[i]; the event is lost.
REQ-017 An edge[i] pulse in the same cycle as grant_clr[i] SHALL leave pending[i]=1 without setting overrun.
REQ-018 ovf_clr=1 SHALL clear all overrun bits, except that a simultaneous new overrun condition on a line sets that bit (set wins).
REQ-019 The arbiter FSM SHALL have two states, IDLE and OFFER.
REQ-020 In IDLE with any pending bit set, the FSM SHALL latch the round-robin winner into evt_id and move to OFFER.
REQ-021 Round-robin search SHALL start at last_grant+1 modulo N and select the first pending line in ascending index order.
REQ-022 In OFFER, evt_valid SHALL be 1 and evt_id SHALL be held stable until the handshake.
REQ-023 On evt_valid & evt_ready, the FSM SHALL return to IDLE and set last_grant to evt_id.
REQ-024 evt_valid SHALL be 0 in IDLE; sustained throughput is therefore 1 event per 2 cycles.
REQ-025 Latency: a 0->1 input sampled at edge t gives edge=1 after t, pending=1 after t+1 and evt_valid=1 after t+2.
REQ-026 evt_ready while evt_valid=0 SHALL have no effect.
REQ-027 The FSM state encoding SHALL cover all codes; any illegal code SHALL go to IDLE.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: FSM to IDLE; evt_valid=0; evt_id=0; pending=0; overrun=0; last_grant=N-1 (so line 0 is checked first); all detectors to HIGH.
REQ-029 A line held high through reset release SHALL produce no event until it goes low and then high again.
REQ-030 Reset asserted during OFFER SHALL drop the offered event silently.

Structure
REQ-031 The shared package edge_pkg SHALL hold the detector state enum (LOW/EDGE/HIGH) and the arbiter state enum (IDLE/OFFER).
REQ-032 The detector SHALL be a sub-module edge_detect (clk, rst_n, in, edge), instantiated N times via generate.
REQ-033 Round-robin selection SHALL be combinational logic inside edge_event_arbiter.

Verification
REQ-034 N=4, evt_ready=1, pulse in[2] high for 3 cycles -> exactly one event, evt_id=2, evt_valid high 2 cycles after edge=1, no overrun.
REQ-035 All in 0->1 in the same cycle, evt_ready=1 -> evt_id sequence 0,1,2,3, one every 2 cycles, pending decrements to 0.
REQ-036 evt_ready=0, two rising edges on in[1] -> overrun[1]=1, pending[1]=1; ovf_clr pulse -> overrun[1]=0.
REQ-037 Offer of id 3 accepted in the same cycle as a new edge[3] -> pending[3] stays 1, overrun[3]=0, id 3 is offered again.
REQ-038 in[0]=1 through reset release -> no event; in[0] 0 then 1 -> one event, id 0.
REQ-039 rst_n asserted mid-OFFER with evt_ready=0 -> evt_valid=0 and pending=0 immediately, without waiting for a clock edge.
